uart_mmio_fifo: RTL and testbench

Memory-mapped UART buffer between the CPU's memory stage and the existing UART transmitter/receiver. It replaces the single-byte DataIn/DataOut handshake with parametrised RX and TX FIFOs, sticky overflow flags and occupancy counts. Software can therefore burst bytes without polling per character. It sits on the CPU I/O decode (0x8000_0000 region); the CPU supplies a 4-bit offset and the block returns registered read data for the writeback stage.

---
 rtl/uart_mmio_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART buffer: RX/TX FIFOs, sticky overflow flags and occupancy
// counts behind a 4-register CPU window with registered read data.
module uart_mmio_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [3:0]        addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready
);

  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam int unsigned RxCw = RxAw + 1;
  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned TxCw = TxAw + 1;

  localparam logic [1:0] RegStatus = 2'd0;
  localparam logic [1:0] RegRxData = 2'd1;
  localparam logic [1:0] RegTxData = 2'd2;
  localparam logic [1:0] RegClear  = 2'd3;

  logic [DATA_W-1:0] rxMem [RX_DEPTH];
  logic [DATA_W-1:0] txMem [TX_DEPTH];

  logic [RxAw-1:0] rxRdPtrQ, rxWrPtrQ;
  logic [RxCw-1:0] rxCountQ;
  logic [TxAw-1:0] txRdPtrQ, txWrPtrQ;
  logic [TxCw-1:0] txCountQ;
  logic            rxOvfQ, txOvfQ;
  logic [31:0]     rdataQ;

  logic [1:0]  regSel;
  logic        effRd, effWr;
  logic        rxFull, rxEmpty, txFull, txEmpty;
  logic        rxPush, rxPop, txPush, txPop, txPushReq;
  logic        rxOvfSet, txOvfSet, rxOvfClr, txOvfClr;
  logic [31:0] statusWord, rdataD;
  logic        unusedBits;

  assign unusedBits = ^{addr[1:0], wdata[31:DATA_W]};

  assign regSel = addr[3:2];
  // A write wins over a simultaneous read, so the read is squashed entirely.
  assign effWr  = wr_en & ~stall;
  assign effRd  = rd_en & ~stall & ~wr_en;

  assign rxFull  = (rxCountQ == RxCw'(RX_DEPTH));
  assign rxEmpty = (rxCountQ == '0);
  assign txFull  = (txCountQ == TxCw'(TX_DEPTH));
  assign txEmpty = (txCountQ == '0);

  // Pops on an empty FIFO are ignored, which also covers push+pop on empty.
  assign rxPop    = effRd & (regSel == RegRxData) & ~rxEmpty;
  assign rxPush   = uart_rx_valid & (~rxFull | rxPop);
  assign rxOvfSet = uart_rx_valid & rxFull & ~rxPop;

  assign txPop     = ~txEmpty & uart_tx_ready;
  assign txPushReq = effWr & (regSel == RegTxData);
  assign txPush    = txPushReq & (~txFull | txPop);
  assign txOvfSet  = txPushReq & txFull & ~txPop;

  assign rxOvfClr = effWr & (regSel == RegClear) & wdata[0];
  assign txOvfClr = effWr & (regSel == RegClear) & wdata[1];

  assign uart_tx_valid = ~txEmpty;
  assign uart_tx_data  = txEmpty ? '0 : txMem[txRdPtrQ];
  assign rdata         = rdataQ;

  // Status word and read-data mux; rdata holds when there is no effective read.
  always_comb begin
    statusWord        = '0;
    statusWord[0]     = ~txFull;
    statusWord[1]     = ~rxEmpty;
    statusWord[2]     = rxOvfQ;
    statusWord[3]     = txOvfQ;
    statusWord[15:8]  = 8'(rxCountQ);
    statusWord[23:16] = 8'(txCountQ);

    rdataD = rdataQ;
    if (effRd) begin
      unique case (regSel)
        RegStatus: rdataD = statusWord;
        RegRxData: rdataD = rxPop ? 32'(rxMem[rxRdPtrQ]) : '0;
        default:   rdataD = '0;
      endcase
    end
  end

  // FIFO storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rxPush) rxMem[rxWrPtrQ] <= uart_rx_data;
    if (txPush) txMem[txWrPtrQ] <= wdata[DATA_W-1:0];
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxRdPtrQ <= '0;
      rxWrPtrQ <= '0;
      rxCountQ <= '0;
    end else begin
      if (rxPush) rxWrPtrQ <= rxWrPtrQ + 1'b1;
      if (rxPop)  rxRdPtrQ <= rxRdPtrQ + 1'b1;
      if (rxPush && !rxPop)      rxCountQ <= rxCountQ + 1'b1;
      else if (!rxPush && rxPop) rxCountQ <= rxCountQ - 1'b1;
    end
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      txRdPtrQ <= '0;
      txWrPtrQ <= '0;
      txCountQ <= '0;
    end else begin
      if (txPush) txWrPtrQ <= txWrPtrQ + 1'b1;
      if (txPop)  txRdPtrQ <= txRdPtrQ + 1'b1;
      if (txPush && !txPop)      txCountQ <= txCountQ + 1'b1;
      else if (!txPush && txPop) txCountQ <= txCountQ - 1'b1;
    end
  end

  // Sticky overflow flags; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxOvfQ <= 1'b0;
      txOvfQ <= 1'b0;
    end else begin
      rxOvfQ <= rxOvfSet | (rxOvfQ & ~rxOvfClr);
      txOvfQ <= txOvfSet | (txOvfQ & ~txOvfClr);
    end
  end

  // Registered load data.
  always_ff @(posedge clk) begin
    if (rst) rdataQ <= '0;
    else     rdataQ <= rdataD;
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed self-checking bench for uart_mmio_fifo (DATA_W=8, depths 8).
module tb_uart_mmio_fifo;

  logic        clk = 1'b0;
  logic        rst, stall, rdEn, wrEn;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic [7:0]  rxData, txData;
  logic        rxValid, txValid, txReady;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  uart_mmio_fifo #(.DATA_W(8), .RX_DEPTH(8), .TX_DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .addr          (addr),
    .rd_en         (rdEn),
    .wr_en         (wrEn),
    .wdata         (wdata),
    .rdata         (rdata),
    .uart_rx_data  (rxData),
    .uart_rx_valid (rxValid),
    .uart_tx_data  (txData),
    .uart_tx_valid (txValid),
    .uart_tx_ready (txReady)
  );

  // Drive helpers: called 1 time unit after a rising edge, return likewise.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuRead(input logic [3:0] a, output logic [31:0] d);
    addr = a; rdEn = 1'b1;
    cycle();
    rdEn = 1'b0;
    d = rdata;
  endtask

  task automatic cpuWrite(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wrEn = 1'b1;
    cycle();
    wrEn = 1'b0;
  endtask

  task automatic rxPulse(input logic [7:0] d);
    rxData = d; rxValid = 1'b1;
    cycle();
    rxValid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    nTests++;
    if (rdata !== 32'h0) begin
      nFail++; $display("FAIL reset_rdata got %h want %h", rdata, 32'h0);
    end
    nTests++;
    if (txValid !== 1'b0 || txData !== 8'h00) begin
      nFail++; $display("FAIL reset_tx got v=%b d=%h want v=0 d=00", txValid, txData);
    end
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0000_0001) begin
      nFail++; $display("FAIL reset_status got %h want %h", d, 32'h0000_0001);
    end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    txReady = 1'b0;
    for (int i = 0; i < 9; i++) cpuWrite(4'h8, 32'h41 + 32'(i));
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0008_0008) begin
      nFail++; $display("FAIL tx_full_status got %h want %h", d, 32'h0008_0008);
    end
    txReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nTests++;
      if (txValid !== 1'b1 || txData !== 8'h41 + 8'(i)) begin
        nFail++;
        $display("FAIL tx_drain[%0d] got v=%b d=%h want v=1 d=%h", i, txValid, txData,
                 8'h41 + 8'(i));
      end
      cycle();
    end
    nTests++;
    if (txValid !== 1'b0) begin
      nFail++; $display("FAIL tx_dropped_byte got v=%b d=%h want v=0", txValid, txData);
    end
    txReady = 1'b0;
    cpuWrite(4'hC, 32'h2);
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0000_0001) begin
      nFail++; $display("FAIL tx_ovf_clear got %h want %h", d, 32'h0000_0001);
    end
  endtask

  task automatic test_tx_full_push_pop();
    logic [31:0] d;
    txReady = 1'b0;
    for (int i = 0; i < 8; i++) cpuWrite(4'h8, 32'h90 + 32'(i));
    // Push onto full TX while the head is popped in the same cycle.
    txReady = 1'b1;
    cpuWrite(4'h8, 32'h99);
    txReady = 1'b0;
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0008_0000) begin
      nFail++; $display("FAIL tx_full_pushpop_status got %h want %h", d, 32'h0008_0000);
    end
    txReady = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    nTests++;
    if (txValid !== 1'b1 || txData !== 8'h99) begin
      nFail++; $display("FAIL tx_full_pushpop_tail got v=%b d=%h want v=1 d=99", txValid, txData);
    end
    cycle();
    txReady = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) rxPulse(8'h10 + 8'(i));
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0000_0807) begin
      nFail++; $display("FAIL rx_full_status got %h want %h", d, 32'h0000_0807);
    end
    for (int i = 0; i < 9; i++) begin
      cpuRead(4'h4, d);
      nTests++;
      if (d !== ((i < 8) ? 32'h10 + 32'(i) : 32'h0)) begin
        nFail++;
        $display("FAIL rx_read[%0d] got %h want %h", i, d, (i < 8) ? 32'h10 + 32'(i) : 32'h0);
      end
    end
    cpuWrite(4'hC, 32'h1);
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0000_0001) begin
      nFail++; $display("FAIL rx_ovf_clear got %h want %h", d, 32'h0000_0001);
    end
  endtask

  task automatic test_rx_full_push_pop();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) rxPulse(8'h20 + 8'(i));
    rxData = 8'h55; rxValid = 1'b1;
    addr = 4'h4; rdEn = 1'b1;
    cycle();
    rxValid = 1'b0; rdEn = 1'b0;
    nTests++;
    if (rdata !== 32'h20) begin
      nFail++; $display("FAIL rx_full_pushpop_head got %h want %h", rdata, 32'h20);
    end
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0000_0803) begin
      nFail++; $display("FAIL rx_full_pushpop_status got %h want %h", d, 32'h0000_0803);
    end
    for (int i = 0; i < 8; i++) cpuRead(4'h4, d);
    nTests++;
    if (d !== 32'h55) begin
      nFail++; $display("FAIL rx_full_pushpop_tail got %h want %h", d, 32'h55);
    end
  endtask

  task automatic test_rx_empty_push_pop();
    logic [31:0] d;
    rxData = 8'h66; rxValid = 1'b1;
    addr = 4'h4; rdEn = 1'b1;
    cycle();
    rxValid = 1'b0; rdEn = 1'b0;
    nTests++;
    if (rdata !== 32'h0) begin
      nFail++; $display("FAIL rx_empty_pushpop_rdata got %h want %h", rdata, 32'h0);
    end
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0000_0103) begin
      nFail++; $display("FAIL rx_empty_pushpop_status got %h want %h", d, 32'h0000_0103);
    end
    cpuRead(4'h4, d);
    nTests++;
    if (d !== 32'h66) begin
      nFail++; $display("FAIL rx_empty_pushpop_data got %h want %h", d, 32'h66);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) rxPulse(8'h30 + 8'(i));
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0000_0303) begin
      nFail++; $display("FAIL stall_pre_status got %h want %h", d, 32'h0000_0303);
    end
    stall = 1'b1; addr = 4'h4; rdEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      nTests++;
      if (rdata !== 32'h0000_0303) begin
        nFail++; $display("FAIL stall_hold[%0d] got %h want %h", i, rdata, 32'h0000_0303);
      end
    end
    stall = 1'b0; rdEn = 1'b0;
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0000_0303) begin
      nFail++; $display("FAIL stall_count got %h want %h", d, 32'h0000_0303);
    end
    for (int i = 0; i < 3; i++) begin
      cpuRead(4'h4, d);
      nTests++;
      if (d !== 32'h30 + 32'(i)) begin
        nFail++; $display("FAIL stall_resume[%0d] got %h want %h", i, d, 32'h30 + 32'(i));
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] d;
    for (int i = 0; i < 20; i++) begin
      cpuWrite(4'h8, 32'hA0 + 32'(i));
      nTests++;
      if (txValid !== 1'b1 || txData !== 8'hA0 + 8'(i)) begin
        nFail++;
        $display("FAIL wrap[%0d] got v=%b d=%h want v=1 d=%h", i, txValid, txData,
                 8'hA0 + 8'(i));
      end
      txReady = 1'b1;
      cycle();
      txReady = 1'b0;
    end
    for (int i = 0; i < 3; i++) cpuWrite(4'h8, 32'hC0 + 32'(i));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    nTests++;
    if (txValid !== 1'b0 || txData !== 8'h00 || rdata !== 32'h0) begin
      nFail++;
      $display("FAIL midstream_reset got v=%b d=%h r=%h want v=0 d=00 r=0", txValid, txData,
               rdata);
    end
    cpuRead(4'h0, d);
    nTests++;
    if (d !== 32'h0000_0001) begin
      nFail++; $display("FAIL midstream_reset_status got %h want %h", d, 32'h0000_0001);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rdEn = 1'b0; wrEn = 1'b0;
    addr = '0; wdata = '0; rxData = '0; rxValid = 1'b0; txReady = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_tx_overflow();
    test_tx_full_push_pop();
    test_rx_overflow();
    test_rx_full_push_pop();
    test_rx_empty_push_pop();
    test_stall();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
